// File: rtl/i_decode.sv
// i_decode: pipeline decode stage. Holds the 32x32 register file (r0 hardwired
// to zero, same-cycle write bypass on reads), decodes the instruction into
// control signals, detects load-use hazards and registers everything into the
// ID/EX pipeline register. Flush and stall both insert a zeroed bubble.
module i_decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IF_ID_INSTR,
  input  logic [31:0] IF_ID_NPC,
  input  logic        EX_MEM_PCSrc,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] MEM_WB_WriteData,
  output logic        STALL,
  output logic [31:0] ID_EX_NPC,
  output logic [31:0] ID_EX_A,
  output logic [31:0] ID_EX_B,
  output logic [31:0] ID_EX_IMM,
  output logic [4:0]  ID_EX_RS,
  output logic [4:0]  ID_EX_RT,
  output logic [4:0]  ID_EX_RD,
  output logic        ID_EX_RegDst,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_Branch,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemToReg,
  output logic [1:0]  ID_EX_ALUOp
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } id_ex_t;

  logic [31:0] regfile_q [32];
  logic [31:0] regfile_d [32];
  id_ex_t      id_ex_q;
  id_ex_t      id_ex_d;

  logic [5:0]  opcode;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  ctrl_t       ctrl;
  logic        uses_rt;
  logic        stall;

  assign opcode  = IF_ID_INSTR[31:26];
  assign rs_addr = IF_ID_INSTR[25:21];
  assign rt_addr = IF_ID_INSTR[20:16];
  assign rd_addr = IF_ID_INSTR[15:11];
  assign imm_ext = {{16{IF_ID_INSTR[15]}}, IF_ID_INSTR[15:0]};
  assign wr_en   = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

  // Register file next state: single write port, r0 never written.
  always_comb begin
    regfile_d = regfile_q;
    if (wr_en) regfile_d[MEM_WB_WriteReg] = MEM_WB_WriteData;
  end

  // Register file storage; reset clears all entries and drops any pending write.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int unsigned i = 0; i < 32; i++) regfile_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 32; i++) regfile_q[i] <= regfile_d[i];
    end
  end

  // Operand reads with same-cycle writeback bypass; r0 always reads zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_addr != 5'd0) rs_val = (wr_en && MEM_WB_WriteReg == rs_addr) ? MEM_WB_WriteData : regfile_q[rs_addr];
    if (rt_addr != 5'd0) rt_val = (wr_en && MEM_WB_WriteReg == rt_addr) ? MEM_WB_WriteData : regfile_q[rt_addr];
  end

  // Opcode decode into controls; unknown opcodes decode with all controls low.
  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b10;
        uses_rt        = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = 2'b01;
        uses_rt     = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use hazard against the load in EX; a flush suppresses the stall.
  always_comb begin
    stall = 1'b0;
    if (!EX_MEM_PCSrc && id_ex_q.ctrl.mem_read && id_ex_q.rt != 5'd0)
      stall = (id_ex_q.rt == rs_addr) || (uses_rt && id_ex_q.rt == rt_addr);
  end

  assign STALL = stall;

  // ID/EX next state: decoded instruction, or an all-zero bubble on stall/flush.
  always_comb begin
    id_ex_d = '0;
    if (!stall && !EX_MEM_PCSrc) begin
      id_ex_d.npc  = IF_ID_NPC;
      id_ex_d.a    = rs_val;
      id_ex_d.b    = rt_val;
      id_ex_d.imm  = imm_ext;
      id_ex_d.rs   = rs_addr;
      id_ex_d.rt   = rt_addr;
      id_ex_d.rd   = rd_addr;
      id_ex_d.ctrl = ctrl;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge CLK) begin
    if (!RST) id_ex_q <= '0;
    else      id_ex_q <= id_ex_d;
  end

  assign ID_EX_NPC      = id_ex_q.npc;
  assign ID_EX_A        = id_ex_q.a;
  assign ID_EX_B        = id_ex_q.b;
  assign ID_EX_IMM      = id_ex_q.imm;
  assign ID_EX_RS       = id_ex_q.rs;
  assign ID_EX_RT       = id_ex_q.rt;
  assign ID_EX_RD       = id_ex_q.rd;
  assign ID_EX_RegDst   = id_ex_q.ctrl.reg_dst;
  assign ID_EX_ALUSrc   = id_ex_q.ctrl.alu_src;
  assign ID_EX_MemRead  = id_ex_q.ctrl.mem_read;
  assign ID_EX_MemWrite = id_ex_q.ctrl.mem_write;
  assign ID_EX_Branch   = id_ex_q.ctrl.branch;
  assign ID_EX_RegWrite = id_ex_q.ctrl.reg_write;
  assign ID_EX_MemToReg = id_ex_q.ctrl.mem_to_reg;
  assign ID_EX_ALUOp    = id_ex_q.ctrl.alu_op;

endmodule
